// File: rtl/dsp48a1_pkg.sv
// Shared constants and helpers for the DSP48A1 pipeline and its result-capture companion.
package dsp48a1_pkg;

  localparam int P_WIDTH = 48;

  localparam string RSTTYPE_SYNC  = "SYNC";
  localparam string RSTTYPE_ASYNC = "ASYNC";

  // Operand path is the slower of the A and B register chains.
  function automatic int calc_latency(input int a0, input int a1, input int b0,
                                      input int b1, input int m, input int p);
    int a_lat;
    int b_lat;
    a_lat = a0 + a1;
    b_lat = b0 + b1;
    return ((a_lat > b_lat) ? a_lat : b_lat) + m + p;
  endfunction

endpackage

// File: rtl/dsp48a1_result_capture_if.sv
// Issue side (ce/in_valid/P/CARRYOUT) and result side (valid/ready FIFO head) of the capture block.
interface dsp48a1_result_capture_if #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             ce;
  logic             in_valid;
  logic [WIDTH-1:0] p_in;
  logic             carry_in;
  logic             ovf_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;

  modport slave (
    input  ce, in_valid, p_in, carry_in, ovf_clr, out_ready,
    output out_valid, out_data, count, full, empty, overflow
  );

  modport master (
    output ce, in_valid, p_in, carry_in, ovf_clr, out_ready,
    input  out_valid, out_data, count, full, empty, overflow
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; head is read combinationally from storage.
module sync_fifo_fwft #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // NOTE: storage carries no reset; empty/count already mask stale entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/dsp48a1_result_capture.sv
// Tracks issued DSP48A1 operations to their result cycle and buffers {CARRYOUT, P} for the consumer.
module dsp48a1_result_capture
  import dsp48a1_pkg::*;
#(
  parameter int WIDTH = P_WIDTH,
  parameter int A0REG = 0,
  parameter int A1REG = 1,
  parameter int B0REG = 0,
  parameter int B1REG = 1,
  parameter int MREG  = 1,
  parameter int PREG  = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dsp48a1_result_capture_if.slave  bus
);
  localparam int L = calc_latency(A0REG, A1REG, B0REG, B1REG, MREG, PREG);

  logic w_arrive;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_drop;
  logic r_overflow;

  if (L == 0) begin : g_lat0
    assign w_arrive = bus.ce & bus.in_valid;
  end else if (L == 1) begin : g_lat1
    logic r_arrive;
    always_ff @(posedge clk) begin
      if (!rst_n) r_arrive <= 1'b0;
      else        r_arrive <= bus.ce & bus.in_valid;
    end
    assign w_arrive = r_arrive;
  end else begin : g_latn
    logic [L-2:0] r_vld;
    logic         r_arrive;
    // Inner stages hold through a stall; the final stage pulses so a stalled result is taken once.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld    <= '0;
        r_arrive <= 1'b0;
      end else begin
        if (bus.ce) begin
          r_vld[0] <= bus.in_valid;
          for (int i = 1; i < L - 1; i++) r_vld[i] <= r_vld[i-1];
        end
        r_arrive <= bus.ce & r_vld[L-2];
      end
    end
    assign w_arrive = r_arrive;
  end

  assign w_pop  = bus.out_ready & ~w_empty;
  assign w_drop = w_arrive & w_full & ~w_pop;

  sync_fifo_fwft #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_arrive),
    .i_data  ({bus.carry_in, bus.p_in}),
    .i_pop   (bus.out_ready),
    .o_data  (bus.out_data),
    .o_count (bus.count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (bus.ovf_clr) r_overflow <= 1'b0;
  end

  assign bus.out_valid = ~w_empty;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;
endmodule

// File: doc/dsp48a1_result_capture.md
Name: dsp48a1_result_capture

Overview:
- Read-side companion to the DSP48A1 pipeline.
- Tracks each issued operation through the configured register stages (A0/A1, B0/B1, M, P), honouring the shared pipeline clock enable.
- Captures P and CARRYOUT when the result arrives and buffers them in a small first-word-fall-through FIFO.
- Results leave on a valid/ready interface, so downstream logic never computes pipeline latency itself.

Parameters:
- WIDTH, 48, width of P.
- A0REG, 0, A0 stage enabled (1/0).
- A1REG, 1, A1 stage enabled.
- B0REG, 0, B0 stage enabled.
- B1REG, 1, B1 stage enabled.
- MREG, 1, multiplier register enabled.
- PREG, 1, P register enabled.
- DEPTH, 4, FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ce  in  1  DSP pipeline clock enable (same signal driving the DSP registers).
- in_valid  in  1  an operation is presented to the DSP inputs this cycle.
- p_in  in  WIDTH  DSP P output.
- carry_in  in  1  DSP CARRYOUT.
- ovf_clr  in  1  clears the sticky overflow flag.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  WIDTH+1  {carry, P} at FIFO head.
- count  out  $clog2(DEPTH+1)  occupancy.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky: a result was dropped.

Behaviour:
- Latency L = max(A0REG+A1REG, B0REG+B1REG) + MREG + PREG. Range 0..4; default 3.
- Valid tracker, L≥1:
  - L-bit shift register vld[0..L-1].
  - vld[0] <= ce ? in_valid : vld[0]. Stages 1..L-2 shift on ce and hold otherwise.
  - Final stage is a one-cycle pulse: arrive = vld[L-1] <= ce & vld[L-2]; for L=1, arrive <= ce & in_valid. It clears to 0 whenever ce=0.
  - A result stalled by ce=0 is therefore captured exactly once.
- Valid tracker, L=0: arrive = ce & in_valid (combinational), capturing p_in in the same cycle.
- in_valid with ce=0 is ignored: the operation was not issued.
- Push: arrive=1. Entry {carry_in, p_in} is written at the clock edge of the arrive cycle.
- Pop: out_valid & out_ready.
- FIFO head:
  - First-word fall-through; out_valid = !empty.
  - out_data shows the head combinationally from storage.
  - out_data is undefined (hold last value) when empty.
- Push when not full: write, count+1.
- Simultaneous push and pop: count unchanged. This is legal when full (head leaves, new entry enters) and when count=1.
- Push when full without pop: entry dropped, count stays DEPTH, overflow<=1.
- Pop when empty: impossible by protocol; count must never underflow.
- Overflow is sticky. ovf_clr clears it; a drop in the same cycle as ovf_clr wins and overflow stays 1.
- Read/write pointers wrap modulo DEPTH.
- Reset (rst_n=0 at edge), including mid-operation:
  - vld, arrive register, pointers and count go to 0; overflow goes to 0.
  - out_valid=0, empty=1, full=0.
  - In-flight and buffered results are discarded.

Decomposition:
- Package dsp48a1_pkg holds:
  - function calc_latency(a0,a1,b0,b1,m,p);
  - localparam P_WIDTH=48;
  - RSTTYPE string constants shared with the pipeline registers.
- One sub-module is natural: sync_fifo_fwft (WIDTH, DEPTH). It provides push/pop/count/full/empty and takes the same clk/rst_n.
- Valid tracker and overflow flag stay in the top module.

Test Plan:
- Defaults, ce=1, out_ready=1, in_valid pulse at cycle 0, p_in=48'h0000_0000_1234 and carry_in=1 during cycle 3 -> arrive in cycle 3; out_valid=1 in cycle 4 with out_data=49'h1_0000_0000_1234; empty again in cycle 5.
- Defaults, in_valid at cycle 0, ce=0 for cycles 1–5 then 1 -> arrive pulses once (cycle 8); exactly one entry pushed; count=1 with out_ready=0.
- Defaults, out_ready=0, five back-to-back ops with P=1..5 -> count=4, full=1, overflow=1; draining yields 1,2,3,4; empty afterwards.
- While full, out_ready=1 and arrive=1 in the same cycle with P=9 -> count stays 4, overflow unchanged, last drained value is 9; ovf_clr pulse -> overflow=0.
- All REG params=0 (L=0), in_valid=1 and ce=1 with P=48'hABC -> out_valid next cycle with 49'h0_0000_0000_0ABC.
- Two entries buffered plus one op in flight, rst_n=0 for one cycle -> count=0, out_valid=0, overflow=0, and no arrive pulse follows.
